// File: rtl/div_if.sv
// div_if: execute-stage handshake and operand/result bundle for the iterative divider
interface div_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  modport master(output start, func3, dividend, divisor, flush, input busy, done, result);
  modport slave(input start, func3, dividend, divisor, flush, output busy, done, result);
endinterface

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring RV32M DIV/DIVU/REM/REMU; DIV_EARLY_OUT_EN skips iteration for divide-by-zero and signed overflow
module div_unit #(parameter int XLEN = 32) (
  input logic clk,
  input logic rst,
  div_if.slave d
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_r, quo_r, dvs_r, res_r;
  logic            is_rem, q_neg, r_neg;
  logic            sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs, fixed;
  logic [XLEN:0]   shifted, diff;
  assign sgn     = ~d.func3[0];
  assign a_neg   = sgn & d.dividend[XLEN-1];
  assign b_neg   = sgn & d.divisor[XLEN-1];
  assign a_abs   = a_neg ? -d.dividend : d.dividend;
  assign b_abs   = b_neg ? -d.divisor : d.divisor;
  // quotient bits enter at the LSB of quo_r while dividend bits leave its MSB
  assign shifted = {rem_r, quo_r[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_r};
  assign fixed   = is_rem ? (r_neg ? -rem_r : rem_r) : (q_neg ? -quo_r : quo_r);
  assign d.busy   = (state == CALC) || (state == FIX);
  assign d.done   = state == DONE;
  assign d.result = res_r;
`ifdef DIV_EARLY_OUT_EN
  logic            div0, ovf, early;
  logic [XLEN-1:0] special;
  assign div0    = d.divisor == '0;
  assign ovf     = sgn && d.dividend == {1'b1, {(XLEN-1){1'b0}}} && (&d.divisor);
  assign early   = div0 | ovf;
  assign special = div0 ? (d.func3[1] ? d.dividend : '1) : (d.func3[1] ? '0 : d.dividend);
`endif
  // control FSM and restoring datapath; a zero divisor leaves the quotient sign uncorrected so it stays all ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      dvs_r  <= '0;
      res_r  <= '0;
      is_rem <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
    end else if (d.flush) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      if (d.start) begin
        is_rem <= d.func3[1];
        q_neg  <= (a_neg ^ b_neg) & (d.divisor != '0);
        r_neg  <= a_neg;
        quo_r  <= a_abs;
        dvs_r  <= b_abs;
        rem_r  <= '0;
        cnt    <= '0;
        state  <= CALC;
`ifdef DIV_EARLY_OUT_EN
        if (early) begin
          res_r <= special;
          state <= DONE;
        end
`endif
      end
    end else if (state == CALC) begin
      rem_r <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      quo_r <= {quo_r[XLEN-2:0], ~diff[XLEN]};
      cnt   <= cnt + 1'b1;
      if (cnt == CW'(XLEN-1)) state <= FIX;
    end else if (state == FIX) begin
      res_r <= fixed;
      state <= DONE;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an arithmetic reference model
module tb_div_unit;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vec = 0;
  int err = 0;
  div_if #(.XLEN(32)) d();
  div_unit #(.XLEN(32)) dut(.clk(clk), .rst(rst), .d(d));
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return f[1] ? a : 32'hFFFFFFFF;
    if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f[1] ? 32'h0 : a;
    case (f)
      3'b100: return $signed(a) / $signed(b);
      3'b101: return a / b;
      3'b110: return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic bit special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction

  // idx: 1-based count of falling edges after the accepting edge at which done was seen
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int idx, output int bcnt, output int ovl);
    @(negedge clk);
    d.start = 1'b1; d.func3 = f; d.dividend = a; d.divisor = b;
    @(negedge clk);
    d.start = 1'b0;
    idx = 1; bcnt = 0; ovl = 0;
    while (!d.done && idx < 100) begin
      if (d.busy) bcnt++;
      @(negedge clk);
      idx++;
    end
    if (d.busy && d.done) ovl++;
    res = d.result;
  endtask

  task automatic test_reset();
    d.start = 0; d.flush = 0; d.func3 = 3'b100; d.dividend = 0; d.divisor = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vec++; if (d.busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b want 0", d.busy); end
    vec++; if (d.done !== 1'b0) begin err++; $display("FAIL reset_done got %b want 0", d.done); end
    vec++; if (d.result !== 32'h0) begin err++; $display("FAIL reset_result got %h want 0", d.result); end
    rst = 1'b0;
  endtask

  task automatic test_table();
    logic [2:0] f [14] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110, 3'b100, 3'b111, 3'b110,
                           3'b100, 3'b110, 3'b101, 3'b111, 3'b101};
    logic [31:0] a [14] = '{100, 100, -7, -7, 7, 7, 5, 5, -5,
                            32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 0};
    logic [31:0] b [14] = '{7, 7, 2, 2, -2, -2, 0, 0, 0,
                            32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1};
    logic [31:0] want [14] = '{14, 2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 32'hFFFFFFFF, 5,
                               32'hFFFFFFFB, 32'h80000000, 0, 0, 32'h80000000, 0};
    logic [31:0] res;
    int idx, bcnt, ovl, wi, wb;
    for (int i = 0; i < 14; i++) begin
      run_op(f[i], a[i], b[i], res, idx, bcnt, ovl);
      wi = (EARLY && special(f[i], a[i], b[i])) ? 1 : 34;
      wb = (EARLY && special(f[i], a[i], b[i])) ? 0 : 33;
      vec++; if (res !== want[i]) begin err++; $display("FAIL table%0d_result f=%b a=%h b=%h got %h want %h", i, f[i], a[i], b[i], res, want[i]); end
      vec++; if (idx !== wi) begin err++; $display("FAIL table%0d_latency got edge %0d want %0d", i, idx, wi); end
      vec++; if (bcnt !== wb) begin err++; $display("FAIL table%0d_busy_cycles got %0d want %0d", i, bcnt, wb); end
      vec++; if (ovl !== 0) begin err++; $display("FAIL table%0d_busy_and_done got %0d want 0", i, ovl); end
    end
  endtask

  task automatic test_random();
    logic [2:0] f;
    logic [31:0] a, b, res, want;
    int idx, bcnt, ovl, wi, m;
    for (int i = 0; i < 24; i++) begin
      f = 3'b100 | 3'($urandom_range(3));
      a = ($urandom_range(5) == 0) ? 32'h80000000 : $urandom;
      m = $urandom_range(7);
      b = (m == 0) ? 32'h0 : (m == 1) ? 32'hFFFFFFFF : (m == 2) ? 32'($urandom_range(20, 1)) : $urandom;
      want = model(f, a, b);
      wi = (EARLY && special(f, a, b)) ? 1 : 34;
      run_op(f, a, b, res, idx, bcnt, ovl);
      vec++; if (res !== want) begin err++; $display("FAIL rand%0d_result f=%b a=%h b=%h got %h want %h", i, f, a, b, res, want); end
      vec++; if (idx !== wi) begin err++; $display("FAIL rand%0d_latency got edge %0d want %0d", i, idx, wi); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prior, res;
    int idx, bcnt, ovl;
    bit seen;
    prior = d.result;
    @(negedge clk);
    d.start = 1'b1; d.func3 = 3'b101; d.dividend = 1000; d.divisor = 7;
    @(negedge clk);
    d.start = 1'b0;
    repeat (9) @(negedge clk);
    d.flush = 1'b1;
    @(negedge clk);
    d.flush = 1'b0;
    vec++; if (d.busy !== 1'b0) begin err++; $display("FAIL flush_busy got %b want 0", d.busy); end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (d.done) seen = 1;
    end
    vec++; if (seen !== 1'b0) begin err++; $display("FAIL flush_no_done got %b want 0", seen); end
    vec++; if (d.result !== prior) begin err++; $display("FAIL flush_result_held got %h want %h", d.result, prior); end
    run_op(3'b101, 9, 3, res, idx, bcnt, ovl);
    vec++; if (res !== 32'd3) begin err++; $display("FAIL after_flush_result got %h want 3", res); end
    vec++; if (idx !== 34) begin err++; $display("FAIL after_flush_latency got edge %0d want 34", idx); end
  endtask

  task automatic test_back_to_back();
    int idx;
    @(negedge clk);
    d.start = 1'b1; d.func3 = 3'b101; d.dividend = 100; d.divisor = 7;
    @(negedge clk);
    idx = 1;
    while (!d.done && idx < 100) begin
      d.start = (idx < 20) ? idx[0] : 1'b0;
      d.func3 = 3'b100; d.dividend = $urandom; d.divisor = $urandom;
      @(negedge clk);
      idx++;
    end
    d.start = 1'b0;
    vec++; if (d.result !== 32'd14) begin err++; $display("FAIL start_ignored_result got %h want 14", d.result); end
    vec++; if (idx !== 34) begin err++; $display("FAIL start_ignored_latency got edge %0d want 34", idx); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int idx, bcnt, ovl;
    @(negedge clk);
    d.start = 1'b1; d.func3 = 3'b101; d.dividend = 500; d.divisor = 3;
    @(negedge clk);
    d.start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    vec++; if (d.busy !== 1'b0) begin err++; $display("FAIL async_rst_busy got %b want 0", d.busy); end
    vec++; if (d.done !== 1'b0) begin err++; $display("FAIL async_rst_done got %b want 0", d.done); end
    vec++; if (d.result !== 32'h0) begin err++; $display("FAIL async_rst_result got %h want 0", d.result); end
    @(negedge clk);
    rst = 1'b0;
    run_op(3'b111, 500, 3, res, idx, bcnt, ovl);
    vec++; if (res !== 32'd2) begin err++; $display("FAIL after_rst_result got %h want 2", res); end
  endtask

  initial begin
    test_reset();
    test_table();
    test_random();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 divider that implements the RV32M DIV, DIVU, REM and REMU operations beside the execute stage. The execute stage issues one operation with a start pulse and holds the pipeline while `busy` is high. It consumes the result on the one-cycle `done` pulse and forwards it into the EX/MEM pipeline register as the ALU result. Operands arrive already forwarded (op1/op2 after selection); the unit keeps no pipeline state of its own beyond the single in-flight operation.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; the iteration count equals XLEN.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a divide; sampled only in IDLE.
- `func3`  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; latched with `start`.
- `dividend`  in  XLEN  op1 (rs1); latched with `start`.
- `divisor`  in  XLEN  op2 (rs2); latched with `start`.
- `flush`  in  1  abort the in-flight operation (branch/exception squash).
- `busy`  out  1  high while an operation is in CALC or FIX.
- `done`  out  1  single-cycle pulse; `result` is valid in this cycle.
- `result`  out  XLEN  quotient or remainder; holds its value until the next completion.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE with `start`=1 and `flush`=0:
  - Latch op kind and signedness.
  - Latch |dividend| and |divisor|; absolute value applies only for DIV/REM.
  - Record the quotient sign (operand signs differ) and the remainder sign (dividend sign).
  - Clear the partial remainder and the counter, then go to CALC.
- CALC performs one restoring step per cycle:
  - Shift the partial remainder left, bringing in the dividend MSB.
  - Compute the trial subtraction against |divisor|.
  - On no borrow, keep the difference and shift in a quotient bit of 1; otherwise shift in 0.
  - The counter increments each cycle; the edge with counter = XLEN-1 moves to FIX.
- FIX:
  - Apply sign correction (two's-complement negate if the recorded sign is set) to the quotient or remainder.
  - Register it into `result`, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Required special-case results:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the original dividend. Sign correction is suppressed.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0.
- `start` outside IDLE is ignored; the execute stage holds it until accepted.
- `flush`=1 in any state moves to IDLE on the next edge:
  - No `done` pulse; `result` is unchanged.
  - `flush` has priority over `start` in the same cycle.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, counter 0.
- Asynchronous reset mid-operation forces these values immediately, with no `done` pulse.
- Let E0 be the edge that accepts `start`:
  - `busy` is high from E0 until E33.
  - `done` is high between E33 and E34.
  - Latency is 33 cycles; throughput is one operation per 35 cycles (IDLE is re-entered before the next accept).
- `busy` and `done` are never high in the same cycle.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - Divisor 0 and signed overflow are detected combinationally in IDLE.
  - E0 loads `result` with the special value and goes directly to DONE; `done` is high between E0 and E1 (latency 1).
  - `busy` stays low throughout.
- Undefined: these cases run the full CALC/FIX sequence with latency 33 and produce identical result values.

## Test plan
- DIVU 100/7: `busy` is high for 33 cycles, `done` pulses at E33, `result`=14. REMU 100/7 gives 2.
- DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIV 7/-2 gives 0xFFFFFFFD; REM 7/-2 gives 1.
- DIV 5/0 gives 0xFFFFFFFF, REMU 5/0 gives 5, REM -5/0 gives 0xFFFFFFFB. Latency is 33 without `DIV_EARLY_OUT_EN` and 1 with it.
- DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0. DIVU of the same operands gives 0 and REMU gives 0x80000000.
- `flush` asserted 10 cycles after E0:
  - `busy` drops the next cycle, no `done` follows, `result` keeps the prior value.
  - A following DIVU 9/3 returns 3 at normal latency.
- `start` toggled while busy is ignored and the first result is unchanged. `rst` asserted mid-CALC zeroes `busy`, `done` and `result` immediately.
